sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Target-side model of the 16-bit asynchronous SRAM bus (20-bit address, 16-bit bidirectional data, active-low write strobe). It answers the board RAM tester and other SRAM initiators on boards with no physical SRAM fitted.
- Storage is an internal block RAM of 2^ADDR_W words. Addresses mirror modulo the depth.
- After reset, a built-in clear engine fills the RAM with CLEAR_VALUE.
- Fault-injection and write-count outputs let the bench force and observe pass/fail outcomes of the tester.

Parameters:
- ADDR_W, 14, implemented address bits (depth 2^ADDR_W words, 1..20); sram_a[19:ADDR_W] ignored (mirroring).
- CLEAR_VALUE, 16'h0000, word written to every location by the clear engine.

Ports:
- clk  in  1  system clock, same clock as the initiator.
- rst_n  in  1  asynchronous active-low reset.
- sram_a  in  20  word address from the initiator.
- sram_d  inout  16  data bus. Driven by this block when sram_we_n=1; high-Z when sram_we_n=0.
- sram_we_n  in  1  active-low write strobe.
- clear_req  in  1  pulse: restart the clear engine.
- fault_en  in  1  enable read-data corruption.
- fault_addr  in  20  address (compared over ADDR_W bits) whose reads are corrupted.
- fault_mask  in  16  XOR mask applied to corrupted reads.
- ready  out  1  1 = RUN state, clear complete.
- wr_count  out  32  number of write strobes accepted since reset or clear.
- last_wr_addr  out  20  sram_a of the most recent accepted write strobe.

Behaviour:
- Reset (rst_n=0, async):
  - state=CLEAR, clr_addr=0, ready=0, rd_q=16'h0000, we_n_q=1, wr_count=0, last_wr_addr=0.
  - RAM contents are not reset.
- FSM has two states:
  - CLEAR: each cycle writes CLEAR_VALUE to mem[clr_addr] and increments clr_addr. On the cycle clr_addr = 2^ADDR_W-1: write, then go to RUN and set ready=1 on the next edge. The clear therefore lasts exactly 2^ADDR_W cycles.
  - RUN: serves the bus. clear_req=1 in any state (sampled synchronously) sets state=CLEAR, clr_addr=0, ready=0, wr_count=0. clear_req during CLEAR restarts the clear from address 0.
- Write path (RUN only):
  - Every cycle with sram_we_n=0 writes sram_d into mem[sram_a[ADDR_W-1:0]]. Level-sensitive, so a multi-cycle strobe rewrites the same data harmlessly.
  - Falling-edge detect (we_n_q=1, sram_we_n=0) increments wr_count and loads last_wr_addr. A strobe held low counts once.
  - wr_count wraps 32'hFFFFFFFF -> 0.
- Writes in CLEAR are ignored and not counted. A strobe already low when RUN is entered counts only after a fresh falling edge.
- Read path:
  - rd_q <= mem[sram_a[ADDR_W-1:0]] every cycle, giving a 1-cycle registered latency. Data for an address presented before edge N is on sram_d after edge N.
  - Write-first: a write and a read of the same address in the same cycle returns the new data on the next cycle.
  - In CLEAR, rd_q <= CLEAR_VALUE.
- Fault injection: in RUN, when fault_en=1 and sram_a[ADDR_W-1:0]==fault_addr[ADDR_W-1:0], rd_q takes the read data XOR fault_mask. Stored contents are never altered.
- Bus drive:
  - sram_d = rd_q when sram_we_n=1, else high-Z.
  - The output enable is combinational from sram_we_n, so there is no turnaround cycle. This matches an initiator that drives the bus only while its strobe is low.
- Mirroring: address A and A+2^ADDR_W alias to the same word, for both writes and reads.

Test Plan:
- Reset release, ADDR_W=10, CLEAR_VALUE=16'h0000:
  - ready rises exactly 1024 cycles after rst_n deasserts (±1 edge documented); wr_count=0.
  - Reading addresses 0, 511 and 1023 returns 16'h0000 one cycle after the address is applied.
- Write then read:
  - Strobe 1 cycle at address 20'h00005 with data 16'h5555, then read 20'h00005: 16'h5555 on the next cycle.
  - wr_count=1, last_wr_addr=20'h00005.
  - A 4-cycle strobe also gives wr_count=1.
- Aliasing (ADDR_W=10): write 16'hAAAA at 20'h00403, then read 20'h00003: returns 16'hAAAA.
- Fault injection:
  - fault_en=1, fault_addr=20'h00010, fault_mask=16'h0001, location holds 16'hAAAA: read at 0x010 returns 16'hAAAB, read at 0x011 is unaffected.
  - With fault_en=0, the read at 0x010 returns 16'hAAAA.
- Tester loop: connect ramtest-style initiator (ADDR_W=10, full-range mirrored sweep):
  - Fast and slow modes both reach test_result=1.
  - With fault_en=1, mask 16'h8000: test_result=0.
- Mid-run control:
  - clear_req during a write burst: ready=0 next cycle, writes during CLEAR ignored, wr_count=0.
  - After the 1024 clear cycles all words read CLEAR_VALUE.
  - rst_n asserted asynchronously mid-strobe: outputs take reset values immediately.

Source files
------------

// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - address and write-strobe group of the asynchronous SRAM bus
interface sram_responder_if;
    logic [19:0] sram_a;
    logic        sram_we_n;

    modport master (output sram_a, output sram_we_n);
    modport slave  (input  sram_a, input  sram_we_n);
endinterface

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - block-RAM target standing in for an unfitted 16-bit async SRAM
module sram_responder #(
    parameter int          ADDR_W      = 14,
    parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_responder_if.slave     bus,
    inout  wire  [15:0]         sram_d,
    input  logic                clear_req,
    input  logic                fault_en,
    input  logic [19:0]         fault_addr,
    input  logic [15:0]         fault_mask,
    output logic                ready,
    output logic [31:0]         wr_count,
    output logic [19:0]         last_wr_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_addr_q;
    logic                ready_q;
    logic [15:0]         rd_q;
    logic [15:0]         rd_d;
    logic                we_n_q;
    logic [31:0]         wr_count_q;
    logic [19:0]         last_wr_addr_q;

    logic [15:0]         mem [DEPTH];

    logic [ADDR_W-1:0]   bus_addr;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [15:0]         mem_wdata;
    logic                wr_fall;
    logic                unused_fault_hi;

    // Only the low ADDR_W address bits select a word; the rest mirror.
    assign bus_addr        = bus.sram_a[ADDR_W-1:0];
    assign unused_fault_hi = ^fault_addr;
    assign wr_fall         = we_n_q & ~bus.sram_we_n;

    // Single RAM write port shared by the clear engine and the bus.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus_addr;
        mem_wdata = sram_d;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = CLEAR_VALUE;
        end else if (!bus.sram_we_n) begin
            mem_we = 1'b1;
        end
    end

    // RAM array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Next read word: write-first bypass, forced clear value, then fault XOR.
    always_comb begin
        rd_d = mem[bus_addr];
        if (mem_we && (mem_waddr == bus_addr)) begin
            rd_d = mem_wdata;
        end
        if (state_q == ST_CLEAR) begin
            rd_d = CLEAR_VALUE;
        end else if (fault_en && (bus_addr == fault_addr[ADDR_W-1:0])) begin
            rd_d = rd_d ^ fault_mask;
        end
    end

    // Control FSM: clear sweep, bus service, write-strobe accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_CLEAR;
            clr_addr_q     <= '0;
            ready_q        <= 1'b0;
            rd_q           <= 16'h0000;
            we_n_q         <= 1'b1;
            wr_count_q     <= 32'd0;
            last_wr_addr_q <= 20'd0;
        end else begin
            rd_q   <= rd_d;
            // Tracks the strobe in every state so a strobe already low on
            // entry to RUN needs a fresh falling edge to be counted.
            we_n_q <= bus.sram_we_n;
            if (clear_req) begin
                state_q    <= ST_CLEAR;
                clr_addr_q <= '0;
                ready_q    <= 1'b0;
                wr_count_q <= 32'd0;
            end else begin
                case (state_q)
                    ST_CLEAR: begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                        if (clr_addr_q == {ADDR_W{1'b1}}) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (wr_fall) begin
                            wr_count_q     <= wr_count_q + 32'd1;
                            last_wr_addr_q <= bus.sram_a;
                        end
                    end
                    default: state_q <= ST_CLEAR;
                endcase
            end
        end
    end

    // Drive the data bus whenever the initiator is not writing.
    assign sram_d       = bus.sram_we_n ? rd_q : 16'hzzzz;
    assign ready        = ready_q;
    assign wr_count     = wr_count_q;
    assign last_wr_addr = last_wr_addr_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - scoreboard bench for sram_responder
module tb_sram_responder;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        fault_en = 1'b0;
    logic [19:0] fault_addr = 20'd0;
    logic [15:0] fault_mask = 16'd0;
    logic        ready;
    logic [31:0] wr_count;
    logic [19:0] last_wr_addr;
    wire  [15:0] sram_d;
    logic [15:0] tb_d = 16'd0;
    logic        tb_oe = 1'b0;

    sram_responder_if bus ();

    assign sram_d = tb_oe ? tb_d : 16'hzzzz;

    sram_responder #(.ADDR_W(AW), .CLEAR_VALUE(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .sram_d       (sram_d),
        .clear_req    (clear_req),
        .fault_en     (fault_en),
        .fault_addr   (fault_addr),
        .fault_mask   (fault_mask),
        .ready        (ready),
        .wr_count     (wr_count),
        .last_wr_addr (last_wr_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [19:0] addr;
        logic [15:0] exp;
    } sb_t;

    sb_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Pop expected read data when the DUT presents it, one cycle after the address.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            sb_t e;
            e = sb_q.pop_front();
            check($sformatf("rd@%05h", e.addr), {16'd0, sram_d}, {16'd0, e.exp});
        end
    end

    task automatic sb_read(input logic [19:0] addr, input logic [15:0] exp);
        sb_t e;
        @(negedge clk);
        bus.sram_a    = addr;
        bus.sram_we_n = 1'b1;
        tb_oe         = 1'b0;
        e.due  = cyc + 1;
        e.addr = addr;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic bus_write(input logic [19:0] addr, input logic [15:0] data, input int len);
        @(negedge clk);
        bus.sram_a    = addr;
        tb_d          = data;
        tb_oe         = 1'b1;
        bus.sram_we_n = 1'b0;
        repeat (len - 1) @(negedge clk);
        @(negedge clk);
        bus.sram_we_n = 1'b1;
        tb_oe         = 1'b0;
    endtask

    task automatic direct_read(input logic [19:0] addr, output logic [15:0] data);
        @(negedge clk);
        bus.sram_a    = addr;
        bus.sram_we_n = 1'b1;
        tb_oe         = 1'b0;
        @(posedge clk);
        #1;
        data = sram_d;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    function automatic logic [15:0] pat(input int a);
        return 16'(a) ^ 16'h5A5A ^ 16'(a << 6);
    endfunction

    // ramtest-style initiator: mirrored write sweep, then mirrored read-back.
    task automatic run_tester(input bit slow, output bit result);
        logic [15:0] rd;
        result = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            bus_write({4'(a * 7), 6'd0, 10'(a)}, pat(a), slow ? 3 : 1);
            if (slow) @(negedge clk);
        end
        for (int a = 0; a < DEPTH; a++) begin
            direct_read({4'(a * 3 + 5), 6'(a), 10'(a)}, rd);
            if (rd !== pat(a)) result = 1'b0;
            if (slow) @(negedge clk);
        end
    endtask

    initial begin
        int   n;
        bit   res;
        logic [15:0] exp_w;

        bus.sram_a    = 20'd0;
        bus.sram_we_n = 1'b1;
        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_wr_count", wr_count, 32'd0);
        check("rst_last_addr", {12'd0, last_wr_addr}, 32'd0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        check("clear_cycles", n, DEPTH);
        check("wr_count_after_clear", wr_count, 32'd0);

        sb_read(20'd0,   16'h0000);
        sb_read(20'd511, 16'h0000);
        sb_read(20'd1023, 16'h0000);

        bus_write(20'h00005, 16'h5555, 1);
        sb_read(20'h00005, 16'h5555);
        @(negedge clk);
        check("wr_count_1", wr_count, 32'd1);
        check("last_addr_5", {12'd0, last_wr_addr}, 32'h00005);

        bus_write(20'h00006, 16'h1234, 4);
        check("wr_count_4cyc", wr_count, 32'd2);
        sb_read(20'h00006, 16'h1234);

        bus_write(20'h00403, 16'hAAAA, 1);
        sb_read(20'h00003, 16'hAAAA);
        check("last_addr_alias", {12'd0, last_wr_addr}, 32'h00403);

        bus_write(20'h00010, 16'hAAAA, 1);
        bus_write(20'h00011, 16'hAAAA, 1);
        @(negedge clk);
        fault_en   = 1'b1;
        fault_addr = 20'h00010;
        fault_mask = 16'h0001;
        sb_read(20'h00010, 16'hAAAB);
        sb_read(20'h00011, 16'hAAAA);
        sb_read(20'h00410, 16'hAAAB);
        @(negedge clk);
        fault_en = 1'b0;
        sb_read(20'h00010, 16'hAAAA);

        run_tester(1'b0, res);
        check("tester_fast", {31'd0, res}, 32'd1);
        run_tester(1'b1, res);
        check("tester_slow", {31'd0, res}, 32'd1);
        @(negedge clk);
        fault_en   = 1'b1;
        fault_addr = 20'h00123;
        fault_mask = 16'h8000;
        run_tester(1'b0, res);
        check("tester_fault", {31'd0, res}, 32'd0);
        @(negedge clk);
        fault_en = 1'b0;

        // Clear request lands during a write burst; strobe held low across RUN entry.
        bus_write(20'h00020, 16'h1111, 1);
        @(negedge clk);
        bus.sram_a    = 20'h00021;
        tb_d          = 16'h2222;
        tb_oe         = 1'b1;
        bus.sram_we_n = 1'b0;
        clear_req     = 1'b1;
        @(posedge clk);
        #1;
        check("clr_ready_low", {31'd0, ready}, 32'd0);
        check("clr_wr_count", wr_count, 32'd0);
        clear_req  = 1'b0;
        bus.sram_a = 20'h00007;
        tb_d       = 16'hBEEF;
        wait_ready(n);
        check("reclear_cycles", n, DEPTH);
        check("clr_writes_ignored", wr_count, 32'd0);
        @(negedge clk);
        @(negedge clk);
        bus.sram_we_n = 1'b1;
        tb_oe         = 1'b0;
        check("held_strobe_uncounted", wr_count, 32'd0);
        bus_write(20'h00030, 16'h3333, 1);
        check("fresh_strobe_counted", wr_count, 32'd1);
        for (int a = 0; a < DEPTH; a++) begin
            exp_w = (a == 7) ? 16'hBEEF : (a == 'h30) ? 16'h3333 : 16'h0000;
            sb_read(20'(a), exp_w);
        end
        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);

        // Asynchronous reset in the middle of a strobe.
        @(negedge clk);
        bus.sram_a    = 20'h00040;
        tb_d          = 16'h4444;
        tb_oe         = 1'b1;
        bus.sram_we_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ready", {31'd0, ready}, 32'd0);
        check("async_wr_count", wr_count, 32'd0);
        check("async_last_addr", {12'd0, last_wr_addr}, 32'd0);
        bus.sram_we_n = 1'b1;
        tb_oe         = 1'b0;
        #1;
        check("async_rd_zero", {16'd0, sram_d}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
